// File: rtl/mem_req_ctrl.sv
// Request sequencer in front of a synchronous memory: queues read/write commands,
// issues each as a one-cycle enable pulse, and returns read data over valid/ready.
module mem_req_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_rw,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [AW-1:0] rsp_addr,
  output logic [DW-1:0] rsp_rdata,
  output logic          mem_en,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = 1 + AW + DW;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]    state;
  logic [EW-1:0] fifo [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [PW:0]   count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  // Ready is forced low while reset is held so every output reads 0 during reset.
  assign req_ready = !rst && !full;
  assign push      = req_valid && req_ready;
  assign pop       = (state == IDLE) && !empty;
  assign busy      = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) fifo[wptr] <= {req_rw, req_addr, req_wdata};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // The mem_* registers double as the command register: loaded on pop, held afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_en    <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_rdata <= '0;
    end else begin
      mem_en <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            {mem_rw, mem_addr, mem_wdata} <= fifo[rptr];
            mem_en <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: state <= mem_rw ? IDLE : WAIT;
        WAIT: begin
          rsp_rdata <= mem_rdata;
          rsp_addr  <= mem_addr;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl: directed latency/backpressure/reset cases plus
// randomized traffic scored against an in-order command/response model with a shadow memory.
module tb_mem_req_ctrl;

  typedef struct packed {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_rw;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_addr, rsp_rdata;
  logic       mem_en, mem_rw;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       busy;

  int unsigned errs = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;
  int unsigned en_cnt = 0;
  int unsigned rsp_cnt = 0;
  logic        rand_on = 1'b0;

  cmd_t        exp_cmd [$];
  logic [15:0] exp_rsp [$];
  int unsigned en_cyc  [$];
  logic [7:0]  en_addr [$];

  logic [7:0] ram       [256];
  logic       ram_wr    [256];
  logic [7:0] shadow    [256];
  logic       shadow_wr [256];

  always #5 clk = ~clk;

  mem_req_ctrl #(.DEPTH(4), .AW(8), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return (a == 8'h3C) ? 8'h77 : (a ^ 8'hA5);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Synchronous memory model: read data appears the cycle after an enable.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_rw) begin
        ram[mem_addr]    <= mem_wdata;
        ram_wr[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= ram_wr[mem_addr] === 1'b1 ? ram[mem_addr] : init_val(mem_addr);
      end
    end
  end

  // Reference model: commands leave in acceptance order; a read returns the shadow
  // memory contents as of all writes accepted before it.
  logic       prev_en = 1'b0, prev_rv = 1'b0, prev_rr = 1'b0;
  logic [7:0] prev_ra = '0, prev_rd = '0;
  always @(negedge clk) begin
    cmd_t        c;
    logic [15:0] r;
    cyc++;
    if (rst) begin
      exp_cmd.delete();
      exp_rsp.delete();
      prev_en = 1'b0;
      prev_rv = 1'b0;
    end else begin
      if (mem_en) begin
        check("en_back2back", prev_en, 1'b0);
        if (exp_cmd.size() == 0) check("en_unexp", mem_en, 1'b0);
        else begin
          c = exp_cmd.pop_front();
          check("mem_rw", mem_rw, c.rw);
          check("mem_addr", mem_addr, c.addr);
          if (c.rw) check("mem_wdata", mem_wdata, c.data);
        end
        en_cnt++;
        en_cyc.push_back(cyc);
        en_addr.push_back(mem_addr);
      end
      if (prev_rv && !prev_rr) begin
        check("hold_valid", rsp_valid, 1'b1);
        check("hold_addr", rsp_addr, prev_ra);
        check("hold_data", rsp_rdata, prev_rd);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) check("rsp_unexp", rsp_valid, 1'b0);
        else begin
          r = exp_rsp.pop_front();
          check("rsp_addr", rsp_addr, r[15:8]);
          check("rsp_rdata", rsp_rdata, r[7:0]);
        end
        rsp_cnt++;
      end
      if (req_valid && req_ready) begin
        exp_cmd.push_back('{rw: req_rw, addr: req_addr, data: req_wdata});
        if (req_rw) begin
          shadow[req_addr]    = req_wdata;
          shadow_wr[req_addr] = 1'b1;
        end else begin
          exp_rsp.push_back({req_addr,
                             shadow_wr[req_addr] === 1'b1 ? shadow[req_addr] : init_val(req_addr)});
        end
      end
      prev_en = mem_en;
      prev_rv = rsp_valid;
      prev_rr = rsp_ready;
      prev_ra = rsp_addr;
      prev_rd = rsp_rdata;
    end
  end

  task automatic send(input logic rw, input logic [7:0] a, input logic [7:0] d);
    int unsigned n = 0;
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("send_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    @(negedge clk);
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("idle", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp();
    int unsigned n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rsp_seen", rsp_valid, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned lat;
    int unsigned e0;
    int          n;
    rst = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    #3;
    check("rst_outs", {req_ready, rsp_valid, rsp_addr, rsp_rdata, mem_en, mem_rw,
                       mem_addr, mem_wdata, busy}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", req_ready, 1'b1);
    @(posedge clk); #1;

    // Write then read with latency checks
    send(1'b1, 8'h10, 8'hA5);
    @(posedge clk); #1;
    check("wr_en_lat", mem_en, 1'b1);
    wait_idle();
    send(1'b0, 8'h10, 8'h00);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("rd_lat", lat, 3);
    check("rd_addr", rsp_addr, 8'h10);
    check("rd_data", rsp_rdata, 8'hA5);
    wait_idle();

    // Fill and backpressure
    rsp_ready = 1'b0;
    send(1'b0, 8'h20, 8'h00);
    for (int i = 0; i < 4; i++) send(1'b1, 8'(8'h80 + i), 8'(8'hC0 + i));
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 8'h84; req_wdata = 8'hC4;
    e0 = en_cnt;
    repeat (3) begin
      @(negedge clk);
      check("full_ready", req_ready, 1'b0);
      check("full_rsp_valid", rsp_valid, 1'b1);
    end
    check("full_no_issue", en_cnt, e0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    send(1'b1, 8'h84, 8'hC4);
    wait_idle();
    n = en_cyc.size();
    for (int k = n - 4; k < n; k++) check("wr_gap", en_cyc[k] - en_cyc[k-1], 2);
    for (int k = 0; k < 5; k++) check("wr_order", en_addr[n-5+k], 8'(8'h80 + k));
    check("ready_back", req_ready, 1'b1);

    // Response hold
    rsp_ready = 1'b0;
    send(1'b0, 8'h3C, 8'h00);
    wait_rsp();
    e0 = en_cnt;
    repeat (5) begin
      @(negedge clk);
      check("hold5_valid", rsp_valid, 1'b1);
      check("hold5_addr", rsp_addr, 8'h3C);
      check("hold5_data", rsp_rdata, 8'h77);
    end
    check("hold_no_en", en_cnt, e0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_clr", rsp_valid, 1'b0);
    wait_idle();

    // Pointer wrap: alternating write/read pairs
    e0 = rsp_cnt;
    for (int i = 0; i < 10; i++) begin
      send(1'b1, 8'(i), 8'(8'h50 + i));
      send(1'b0, 8'(i), 8'h00);
    end
    wait_idle();
    check("wrap_nrsp", rsp_cnt - e0, 10);

    // Simultaneous push and pop with two entries queued
    rsp_ready = 1'b0;
    send(1'b0, 8'h40, 8'h00);
    send(1'b1, 8'h41, 8'h11);
    send(1'b1, 8'h42, 8'h12);
    wait_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    send(1'b1, 8'h43, 8'h13);
    wait_idle();
    n = en_addr.size();
    for (int k = 0; k < 3; k++) check("pp_order", en_addr[n-3+k], 8'(8'h41 + k));

    // Randomized traffic with random response backpressure
    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          send(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    rsp_ready = 1'b1;
    wait_idle();
    check("cmd_drained", exp_cmd.size(), 0);
    check("rsp_drained", exp_rsp.size(), 0);

    // Reset during WAIT
    send(1'b0, 8'h05, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_quiet", {mem_en, rsp_valid}, 2'b00);
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_outs", {req_ready, rsp_valid, rsp_addr, rsp_rdata, mem_en, mem_rw,
                           mem_addr, mem_wdata, busy}, '0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    e0 = rsp_cnt;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_no_rsp", rsp_valid, 1'b0);
    end
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_ready", req_ready, 1'b1);
    check("post_rst_rsp_cnt", rsp_cnt, e0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
